// File: rtl/store_check_pkg.sv
// Shared types for the store check monitor: FSM states, failure codes and table entries.
package store_check_pkg;

  // Table entries are fixed at this width; the monitor's XLEN is expected to match it.
  localparam int SC_XLEN = 32;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_BAD_CFG  = 2'd3
  } fail_code_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } mon_state_t;

  typedef struct packed {
    logic [SC_XLEN-1:0] addr;
    logic [SC_XLEN-1:0] data;
  } exp_entry_t;

endpackage

// File: rtl/store_check_monitor_if.sv
// Store-port, table-programming and status signals of the store check monitor.
interface store_check_monitor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int IW = $clog2(DEPTH);

  logic            mem_write_m;
  logic [XLEN-1:0] data_address_m;
  logic [XLEN-1:0] store_data_m;
  logic            tbl_we;
  logic [IW-1:0]   tbl_idx;
  logic [XLEN-1:0] tbl_addr;
  logic [XLEN-1:0] tbl_data;
  logic [IW:0]     num_expected;
  logic            arm;
  logic            clear;

  logic            done;
  logic            pass;
  logic [1:0]      fail_code;
  logic [IW-1:0]   fail_idx;
  logic [XLEN-1:0] fail_addr;
  logic [XLEN-1:0] fail_data;
  logic [IW:0]     match_count;
  logic [15:0]     ignored_count;

  modport master (
    output mem_write_m, data_address_m, store_data_m,
    output tbl_we, tbl_idx, tbl_addr, tbl_data, num_expected, arm, clear,
    input  done, pass, fail_code, fail_idx, fail_addr, fail_data,
    input  match_count, ignored_count
  );

  modport slave (
    input  mem_write_m, data_address_m, store_data_m,
    input  tbl_we, tbl_idx, tbl_addr, tbl_data, num_expected, arm, clear,
    output done, pass, fail_code, fail_idx, fail_addr, fail_data,
    output match_count, ignored_count
  );

endinterface

// File: rtl/store_check_table.sv
// Expected-store register file: one synchronous write port, one asynchronous read port.
module store_check_table
  import store_check_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [IW-1:0] wr_idx,
  input  exp_entry_t wr_entry,
  input  logic [IW-1:0] rd_idx,
  output exp_entry_t rd_entry
);

  exp_entry_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/store_check_monitor.sv
// Checks data-memory stores against an ordered table of expected (addr, data) pairs, with watchdog.
// Define STORE_MON_IGNORE_EN to skip and count stores to IGNORE_ADDR.
module store_check_monitor
  import store_check_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter logic [XLEN-1:0] IGNORE_ADDR = XLEN'(96)
) (
  input  logic clk,
  input  logic reset,
  store_check_monitor_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW:0]   NUM_MAX  = (IW+1)'(DEPTH);

  mon_state_t      state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cyc_cnt;
  logic [IW:0]     num_q;
  logic            done_q;
  logic            pass_q;
  fail_code_t      fail_code_q;
  logic [IW-1:0]   fail_idx_q;
  logic [XLEN-1:0] fail_addr_q;
  logic [XLEN-1:0] fail_data_q;
  logic [IW:0]     match_q;
  logic [15:0]     ign_q;

  exp_entry_t cur;
  exp_entry_t wr_entry;
  logic       ignore_hit;
  logic       store_cmp;
  logic       store_ign;
  logic       entry_hit;
  logic       last_entry;
  logic       cfg_ok;

  assign wr_entry = '{addr: bus.tbl_addr, data: bus.tbl_data};

  store_check_table #(.DEPTH(DEPTH)) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (bus.tbl_we && (state == S_IDLE)),
    .wr_idx   (bus.tbl_idx),
    .wr_entry (wr_entry),
    .rd_idx   (idx),
    .rd_entry (cur)
  );

`ifdef STORE_MON_IGNORE_EN
  assign ignore_hit = (bus.data_address_m == IGNORE_ADDR);
`else
  logic unused_ignore_addr;
  assign ignore_hit         = 1'b0;
  assign unused_ignore_addr = ^IGNORE_ADDR;
`endif

  assign store_cmp  = bus.mem_write_m && !ignore_hit;
  assign store_ign  = bus.mem_write_m && ignore_hit;
  assign entry_hit  = (bus.data_address_m == cur.addr) && (bus.store_data_m == cur.data);
  assign last_entry = (({1'b0, idx}) + (IW+1)'(1)) == num_q;
  assign cfg_ok     = (bus.num_expected != '0) && (bus.num_expected <= NUM_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      cyc_cnt     <= '0;
      num_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      fail_idx_q  <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      match_q     <= '0;
      ign_q       <= '0;
    end else if (bus.clear) begin
      // The table survives a clear so the same expectations can be re-armed.
      state       <= S_IDLE;
      idx         <= '0;
      cyc_cnt     <= '0;
      num_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= FC_NONE;
      fail_idx_q  <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      match_q     <= '0;
      ign_q       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.arm) begin
            if (cfg_ok) begin
              state   <= S_RUN;
              idx     <= '0;
              match_q <= '0;
              cyc_cnt <= '0;
              num_q   <= bus.num_expected;
            end else begin
              state       <= S_FAIL;
              done_q      <= 1'b1;
              fail_code_q <= FC_BAD_CFG;
            end
          end
        end
        S_RUN: begin
          cyc_cnt <= cyc_cnt + CW'(1);
          // A compared store decides the cycle even when the watchdog expires with it.
          if (store_cmp) begin
            if (entry_hit) begin
              idx     <= idx + IW'(1);
              match_q <= match_q + (IW+1)'(1);
              if (last_entry) begin
                state  <= S_PASS;
                done_q <= 1'b1;
                pass_q <= 1'b1;
              end
            end else begin
              state       <= S_FAIL;
              done_q      <= 1'b1;
              fail_code_q <= FC_MISMATCH;
              fail_idx_q  <= idx;
              fail_addr_q <= bus.data_address_m;
              fail_data_q <= bus.store_data_m;
            end
          end else if (cyc_cnt == CYC_LAST) begin
            state       <= S_FAIL;
            done_q      <= 1'b1;
            fail_code_q <= FC_TIMEOUT;
            fail_idx_q  <= idx;
          end
          if (store_ign && (ign_q != 16'hFFFF)) begin
            ign_q <= ign_q + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail_code     = fail_code_q;
  assign bus.fail_idx      = fail_idx_q;
  assign bus.fail_addr     = fail_addr_q;
  assign bus.fail_data     = fail_data_q;
  assign bus.match_count   = match_q;
  assign bus.ignored_count = ign_q;

endmodule

// File: tb/tb_store_check_monitor.sv
// Self-checking bench for store_check_monitor: vector table with scoreboard plus corner-case sequences.
module tb_store_check_monitor;
  import store_check_pkg::*;

  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int TMO = 16;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_check_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus_if ();

  store_check_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .IGNORE_ADDR(32'd96)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic        pass;
    logic [1:0]  fc;
    logic [2:0]  fidx;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic [3:0]  mc;
    logic [15:0] ign;
  } exp_t;

  typedef struct {
    string            name;
    int               ntbl;
    logic [2:0][31:0] ta;
    logic [2:0][31:0] td;
    logic [3:0]       num;
    int               nst;
    logic [3:0][31:0] sa;
    logic [3:0][31:0] sd;
    exp_t             e;
  } vec_t;

  vec_t v [NV];
  exp_t sb [$];
  int n_total = 0;
  int n_pass = 0;

  function automatic exp_t ex(input logic p, input logic [1:0] fc, input logic [2:0] fi,
                              input logic [31:0] fa, input logic [31:0] fd,
                              input logic [3:0] mc, input logic [15:0] ig);
    exp_t r;
    r.pass = p; r.fc = fc; r.fidx = fi; r.faddr = fa; r.fdata = fd; r.mc = mc; r.ign = ig;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add_t(input int i, input logic [31:0] a, input logic [31:0] d);
    v[i].ta[v[i].ntbl] = a;
    v[i].td[v[i].ntbl] = d;
    v[i].ntbl++;
  endtask

  task automatic add_s(input int i, input logic [31:0] a, input logic [31:0] d);
    v[i].sa[v[i].nst] = a;
    v[i].sd[v[i].nst] = d;
    v[i].nst++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1; step(); bus_if.clear = 1'b0;
  endtask

  task automatic wr_tbl(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus_if.tbl_we = 1'b1; bus_if.tbl_idx = 3'(idx); bus_if.tbl_addr = a; bus_if.tbl_data = d;
    step();
    bus_if.tbl_we = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] n);
    bus_if.num_expected = n; bus_if.arm = 1'b1; step(); bus_if.arm = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus_if.mem_write_m = 1'b1; bus_if.data_address_m = a; bus_if.store_data_m = d;
    step();
    bus_if.mem_write_m = 1'b0; bus_if.data_address_m = '0; bus_if.store_data_m = '0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!bus_if.done && k < 40) begin
      step();
      k++;
    end
  endtask

  task automatic run_vec(input int i);
    exp_t e;
    int k;
    do_clear();
    for (int t = 0; t < v[i].ntbl; t++) wr_tbl(t, v[i].ta[t], v[i].td[t]);
    sb.push_back(v[i].e);
    do_arm(v[i].num);
    for (int s = 0; s < v[i].nst; s++) store(v[i].sa[s], v[i].sd[s]);
    wait_done(k);
    chk({v[i].name, ".done"}, 32'(bus_if.done), 32'd1);
    e = sb.pop_front();
    chk({v[i].name, ".pass"}, 32'(bus_if.pass), 32'(e.pass));
    chk({v[i].name, ".fail_code"}, 32'(bus_if.fail_code), 32'(e.fc));
    chk({v[i].name, ".fail_idx"}, 32'(bus_if.fail_idx), 32'(e.fidx));
    chk({v[i].name, ".fail_addr"}, bus_if.fail_addr, e.faddr);
    chk({v[i].name, ".fail_data"}, bus_if.fail_data, e.fdata);
    chk({v[i].name, ".match_count"}, 32'(bus_if.match_count), 32'(e.mc));
    chk({v[i].name, ".ignored_count"}, 32'(bus_if.ignored_count), 32'(e.ign));
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus_if.mem_write_m = 1'b0; bus_if.data_address_m = '0; bus_if.store_data_m = '0;
    bus_if.tbl_we = 1'b0; bus_if.tbl_idx = '0; bus_if.tbl_addr = '0; bus_if.tbl_data = '0;
    bus_if.num_expected = '0; bus_if.arm = 1'b0; bus_if.clear = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v[i].ntbl = 0; v[i].nst = 0; v[i].ta = '0; v[i].td = '0; v[i].sa = '0; v[i].sd = '0;
    end
    v[0].name = "single_filter"; v[0].num = 1;
    add_t(0, 100, 25); add_s(0, 96, 7); add_s(0, 96, 9); add_s(0, 100, 25);
`ifdef STORE_MON_IGNORE_EN
    v[0].e = ex(1, 0, 0, 0, 0, 1, 2);
`else
    v[0].e = ex(0, 1, 0, 96, 7, 0, 0);
`endif
    v[1].name = "multi_in_order"; v[1].num = 3;
    add_t(1, 100, 25); add_t(1, 104, 3); add_t(1, 108, 32'hFFFF_FFFF);
    add_s(1, 100, 25); add_s(1, 104, 3); add_s(1, 108, 32'hFFFF_FFFF);
    v[1].e = ex(1, 0, 0, 0, 0, 3, 0);
    v[2].name = "mismatch_data"; v[2].num = 1;
    add_t(2, 100, 25); add_s(2, 100, 24); add_s(2, 100, 25);
    v[2].e = ex(0, 1, 0, 100, 24, 0, 0);
    v[3].name = "mismatch_mid"; v[3].num = 3;
    add_t(3, 100, 25); add_t(3, 104, 3); add_t(3, 108, 5);
    add_s(3, 100, 25); add_s(3, 104, 4); add_s(3, 108, 5);
    v[3].e = ex(0, 1, 1, 104, 4, 1, 0);
    v[4].name = "mismatch_addr"; v[4].num = 1;
    add_t(4, 100, 25); add_s(4, 200, 25);
    v[4].e = ex(0, 1, 0, 200, 25, 0, 0);
    v[5].name = "bad_cfg_zero"; v[5].num = 0;
    v[5].e = ex(0, 3, 0, 0, 0, 0, 0);
    v[6].name = "bad_cfg_big"; v[6].num = 9;
    v[6].e = ex(0, 3, 0, 0, 0, 0, 0);
    v[7].name = "timeout_idle"; v[7].num = 1;
    add_t(7, 100, 25);
    v[7].e = ex(0, 2, 0, 0, 0, 0, 0);
    v[8].name = "timeout_partial"; v[8].num = 3;
    add_t(8, 100, 25); add_t(8, 104, 3); add_t(8, 108, 5);
    add_s(8, 100, 25); add_s(8, 104, 3);
    v[8].e = ex(0, 2, 2, 0, 0, 2, 0);
    v[9].name = "out_of_order"; v[9].num = 2;
    add_t(9, 100, 25); add_t(9, 104, 3); add_s(9, 104, 3); add_s(9, 100, 25);
    v[9].e = ex(0, 1, 0, 104, 3, 0, 0);

    repeat (2) step();
    chk("reset.done", 32'(bus_if.done), 0);
    chk("reset.pass", 32'(bus_if.pass), 0);
    chk("reset.fail_code", 32'(bus_if.fail_code), 0);
    chk("reset.match_count", 32'(bus_if.match_count), 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) run_vec(i);

    // PASS lands exactly one cycle after the deciding store
    do_clear();
    wr_tbl(0, 100, 25); wr_tbl(1, 104, 3); wr_tbl(2, 108, 32'hFFFF_FFFF);
    do_arm(3);
    store(100, 25); store(104, 3);
    chk("pass_lat.before", 32'(bus_if.done), 0);
    store(108, 32'hFFFF_FFFF);
    chk("pass_lat.done", 32'(bus_if.done), 1);
    chk("pass_lat.pass", 32'(bus_if.pass), 1);

    // Watchdog fires after exactly TMO run cycles
    do_clear();
    wr_tbl(0, 100, 25);
    do_arm(1);
    wait_done(k);
    chk("timeout.cycles", 32'(k), 32'(TMO));
    chk("timeout.fail_code", 32'(bus_if.fail_code), 2);

    // Store in the last run cycle beats the watchdog
    do_clear();
    do_arm(1);
    repeat (TMO - 1) step();
    chk("last_cycle.pending", 32'(bus_if.done), 0);
    store(100, 25);
    chk("last_cycle.pass", 32'(bus_if.pass), 1);
    chk("last_cycle.fail_code", 32'(bus_if.fail_code), 0);

    // Table writes while running are dropped
    do_clear();
    do_arm(1);
    wr_tbl(0, 100, 99);
    store(100, 25);
    chk("tbl_we_run.pass", 32'(bus_if.pass), 1);

    // clear wins over arm: a later mismatching store must go unchecked
    do_clear();
    bus_if.clear = 1'b1; bus_if.arm = 1'b1; bus_if.num_expected = 1;
    step();
    bus_if.clear = 1'b0; bus_if.arm = 1'b0;
    store(100, 0);
    repeat (TMO + 4) step();
    chk("clear_arm.done", 32'(bus_if.done), 0);
    chk("clear_arm.fail_code", 32'(bus_if.fail_code), 0);

    // Async reset between edges mid-run
    do_clear();
    wr_tbl(0, 100, 25); wr_tbl(1, 104, 3);
    do_arm(2);
    store(100, 25);
    chk("rst_mid.before", 32'(bus_if.match_count), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.match_count", 32'(bus_if.match_count), 0);
    chk("rst_mid.done", 32'(bus_if.done), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    do_arm(1);
    store(100, 25);
    chk("rst_mid.table_cleared", 32'(bus_if.fail_code), 1);
    do_clear();
    wr_tbl(0, 100, 25);
    do_arm(1);
    store(100, 25);
    chk("rst_mid.rearm_pass", 32'(bus_if.pass), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_check_monitor.md
Name: store_check_monitor

Overview:
- Synthesisable self-check block watching the processor's data-memory write port (mem_write_m, data_address_m, store_data_m) and comparing stores against a programmable ordered table of expected (address, data) pairs.
- Generalises the single-pair pass/fail check to N pairs, with:
  - a scratch-address filter,
  - a watchdog timeout,
  - sticky status and failure capture.
- Sits beside processor_top in simulation and FPGA bring-up builds; status drives LEDs/ILA or the bench.

Parameters:
- XLEN, 32, width of address and data buses.
- DEPTH, 8, number of expected-store table entries.
- TIMEOUT_CYCLES, 4096, cycles allowed in RUN before timeout; must be ≥ 2.
- IGNORE_ADDR, 32'd96, address whose stores are skipped (only with STORE_MON_IGNORE_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_write_m  in  1  store strobe from memory stage.
- data_address_m  in  XLEN  store address.
- store_data_m  in  XLEN  store data.
- tbl_we  in  1  table write strobe; honoured only in IDLE.
- tbl_idx  in  $clog2(DEPTH)  table write index.
- tbl_addr  in  XLEN  expected address.
- tbl_data  in  XLEN  expected data.
- num_expected  in  $clog2(DEPTH)+1  entries to check; sampled on arm.
- arm  in  1  start checking; honoured only in IDLE.
- clear  in  1  return to IDLE from any state.
- done  out  1  check finished (PASS, FAIL or TIMEOUT).
- pass  out  1  all expected stores matched in order.
- fail_code  out  2  0 none, 1 MISMATCH, 2 TIMEOUT, 3 BAD_CFG.
- fail_idx  out  $clog2(DEPTH)  table index at failure.
- fail_addr  out  XLEN  offending store address.
- fail_data  out  XLEN  offending store data.
- match_count  out  $clog2(DEPTH)+1  stores matched so far.
- ignored_count  out  16  stores filtered by IGNORE_ADDR; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any state):
  - state IDLE.
  - All outputs 0.
  - Table entries 0.
  - Counters 0.
- FSM states: IDLE, RUN, PASS, FAIL (covers MISMATCH, TIMEOUT and BAD_CFG; distinguished by fail_code).
- IDLE:
  - tbl_we writes tbl_addr/tbl_data to table[tbl_idx] on the clock edge.
  - arm with num_expected in 1..DEPTH → RUN next cycle; match_count, index and cycle counter cleared.
  - arm with num_expected = 0 or > DEPTH → FAIL, fail_code = 3.
  - Stores are not checked in IDLE.
- RUN:
  - Cycle counter increments every cycle.
  - On a store, evaluated at the rising edge:
    - If the address equals IGNORE_ADDR (filter compiled in), increment ignored_count and skip the compare.
    - Else if address == table[idx].addr and data == table[idx].data, increment idx and match_count. If this was entry num_expected-1 → PASS.
    - Else → FAIL, fail_code = 1; capture idx and the store address/data.
  - Compares are full XLEN equality.
  - Cycle counter reaches TIMEOUT_CYCLES-1 with no terminal event → FAIL, fail_code = 2; fail_idx = current idx; fail_addr/fail_data = 0.
  - A store and the timeout in the same cycle: store evaluation wins.
  - tbl_we and arm are ignored.
- Latency: done, pass and fail fields are registered; they assert the cycle after the deciding store edge.
- PASS/FAIL:
  - Sticky; further stores ignored; counters frozen.
  - done = 1; pass = 1 only in PASS.
- clear:
  - Any state → IDLE next cycle; clears status, counters and capture registers; table retained.
  - clear and arm in the same cycle: clear wins.
- Reset mid-RUN: immediate IDLE, all outputs 0, table cleared.

Optional Feature:
- Macro: STORE_MON_IGNORE_EN.
- Defined: stores to IGNORE_ADDR are skipped and counted in ignored_count.
- Undefined: every store is compared; ignored_count is tied to 0; IGNORE_ADDR is unused.

Decomposition:
- Package store_check_pkg:
  - fail_code_t enum (FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_BAD_CFG).
  - mon_state_t enum (S_IDLE, S_RUN, S_PASS, S_FAIL).
  - exp_entry_t struct {addr, data}.
- One natural sub-module: store_check_table (DEPTH × exp_entry_t register file, one write port, one async read port indexed by idx).
- FSM, counters and capture logic stay in the top module.

Test Plan:
- Single pair, filter on: table[0] = (100, 25), num_expected = 1; stores (96, 7), (96, 9), (100, 25) → pass = 1, fail_code = 0, ignored_count = 2, match_count = 1.
- Multi-entry in order: table = (100, 25), (104, 3), (108, 0xFFFF_FFFF), num_expected = 3; matching stores → PASS one cycle after the third store.
- Mismatch: table[0] = (100, 25); store (100, 24) → fail_code = 1, fail_idx = 0, fail_addr = 100, fail_data = 24; later stores leave the capture unchanged.
- Timeout: TIMEOUT_CYCLES = 16, armed, no stores → fail_code = 2 after exactly 16 RUN cycles. Matching final store in cycle 15 → PASS instead.
- Config and control: arm with num_expected = 0 → fail_code = 3. tbl_we in RUN leaves the table unchanged. clear + arm in the same cycle → IDLE.
- Async reset mid-RUN, asserted between edges → all outputs 0 immediately. Re-arm works. With STORE_MON_IGNORE_EN undefined, store (96, 7) → fail_code = 1.
